// File: rtl/cluster_rate_meter_pkg.sv
// Shared helpers for the cluster rate meter: window length, bar thresholds,
// saturating arithmetic (64-bit internal math) and the bar FSM state type.
package cluster_rate_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_LOAD = 2'd2
    } bar_state_t;

    function automatic logic [63:0] window_len(input logic [63:0] freq, input int speedup);
        return freq >> speedup;
    endfunction

    function automatic logic [63:0] all_ones(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int k = 0; k < n; k++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

    // Threshold for bar segment i, clamped to the largest representable rate.
    function automatic logic [63:0] threshold(input int i, input int log_mode,
                                              input int step, input int width);
        logic [63:0] t;
        t = (log_mode != 0) ? pow10(i + 1) : (64'(i + 1) * 64'(step));
        if (t > all_ones(width)) begin
            t = all_ones(width);
        end
        return t;
    endfunction

    function automatic logic add_saturates(input logic [63:0] a, input logic [63:0] b,
                                           input int width);
        return (a + b) > all_ones(width);
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        return add_saturates(a, b, width) ? all_ones(width) : (a + b);
    endfunction

    function automatic logic shl_saturates(input logic [63:0] a, input int sh, input int width);
        return a > (all_ones(width) >> sh);
    endfunction

    function automatic logic [63:0] sat_shl(input logic [63:0] a, input int sh, input int width);
        return shl_saturates(a, sh, width) ? all_ones(width) : (a << sh);
    endfunction

endpackage

// File: rtl/cluster_rate_meter_bar_encoder.sv
// Serial thermometer encoder: compares the published rate against one
// threshold per cycle and publishes the whole bar at once.
//
//   state   | meaning
//   IDLE    | waiting for a window to close
//   CMP     | comparing rate against threshold[idx], one segment per cycle
//   LOAD    | bar just published from the shadow, returning to IDLE
module rate_bar_encoder
    import cluster_rate_meter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int BAR_WIDTH     = 8,
    parameter int LOGARITHMIC   = 1,
    parameter int BAR_STEP      = 100
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     start,
    input  logic [COUNTER_WIDTH-1:0] rate,
    output logic [BAR_WIDTH-1:0]     bar
);

    localparam int IDX_W = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    if (LOGARITHMIC != 0 && BAR_WIDTH > 9) begin : g_bad_bar
        $error("rate_bar_encoder: BAR_WIDTH must be <= 9 in logarithmic mode");
    end

    logic [COUNTER_WIDTH-1:0] thr_tab [BAR_WIDTH];

    for (genvar g = 0; g < BAR_WIDTH; g++) begin : g_thr
        assign thr_tab[g] = COUNTER_WIDTH'(threshold(g, LOGARITHMIC, BAR_STEP, COUNTER_WIDTH));
    end

    bar_state_t           state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [BAR_WIDTH-1:0] shadow, shadow_next;
    logic [BAR_WIDTH-1:0] bar_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            shadow <= '0;
            bar    <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            shadow <= shadow_next;
            bar    <= bar_next;
        end
    end

    // The bar is published on the edge into LOAD so it is visible during LOAD.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        shadow_next = shadow;
        bar_next    = bar;
        if (clear) begin
            state_next  = ST_IDLE;
            idx_next    = '0;
            shadow_next = '0;
            bar_next    = '0;
        end else if (start) begin
            state_next  = ST_CMP;
            idx_next    = '0;
            shadow_next = '0;
        end else begin
            case (state)
                ST_CMP: begin
                    shadow_next[idx] = (rate >= thr_tab[idx]);
                    if (idx == IDX_W'(BAR_WIDTH - 1)) begin
                        state_next = ST_LOAD;
                        idx_next   = '0;
                        bar_next   = shadow_next;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
                ST_LOAD: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cluster_rate_meter.sv
// Cluster rate meter: sums per-BX cluster counts over a gate window, scales
// the sum to Hz and drives a thermometer bar for the rate LEDs.
module cluster_rate_meter
    import cluster_rate_meter_pkg::*;
#(
    parameter int CLK_FREQUENCY   = 40079000,
    parameter int SPEEDUP_FACTOR  = 4,
    parameter int COUNTER_WIDTH   = 32,
    parameter int INCREMENT_WIDTH = 8,
    parameter int BAR_WIDTH       = 8,
    parameter int LOGARITHMIC     = 1,
    parameter int BAR_STEP        = 100
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [INCREMENT_WIDTH-1:0] increment_i,
    input  logic                       clear_i,
    output logic [COUNTER_WIDTH-1:0]   rate_o,
    output logic                       rate_valid_o,
    output logic [BAR_WIDTH-1:0]       progress_bar_o,
    output logic                       overflow_o
);

    localparam int WINDOW = int'(window_len(64'(CLK_FREQUENCY), SPEEDUP_FACTOR));
    localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    if (WINDOW < 2) begin : g_bad_window
        $error("cluster_rate_meter: WINDOW must be at least 2");
    end
    if (COUNTER_WIDTH > 56 || INCREMENT_WIDTH > 56) begin : g_bad_width
        $error("cluster_rate_meter: widths must fit the 64-bit saturation math");
    end

    logic [CNT_W-1:0]         win_cnt;
    logic [COUNTER_WIDTH-1:0] acc;
    logic [COUNTER_WIDTH-1:0] acc_sum;
    logic [COUNTER_WIDTH-1:0] rate_scaled;
    logic                     acc_sat;
    logic                     rate_sat;
    logic                     terminal;

    assign terminal    = (win_cnt == CNT_W'(WINDOW - 1));
    assign acc_sat     = add_saturates(64'(acc), 64'(increment_i), COUNTER_WIDTH);
    assign acc_sum     = COUNTER_WIDTH'(sat_add(64'(acc), 64'(increment_i), COUNTER_WIDTH));
    assign rate_sat    = shl_saturates(64'(acc_sum), SPEEDUP_FACTOR, COUNTER_WIDTH);
    assign rate_scaled = COUNTER_WIDTH'(sat_shl(64'(acc_sum), SPEEDUP_FACTOR, COUNTER_WIDTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt      <= '0;
            acc          <= '0;
            rate_o       <= '0;
            rate_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else if (clear_i) begin
            win_cnt      <= '0;
            acc          <= '0;
            rate_o       <= '0;
            rate_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else if (terminal) begin
            // The increment seen on the terminal cycle closes this window.
            win_cnt      <= '0;
            acc          <= '0;
            rate_o       <= rate_scaled;
            rate_valid_o <= 1'b1;
            if (acc_sat || rate_sat) begin
                overflow_o <= 1'b1;
            end
        end else begin
            win_cnt      <= win_cnt + CNT_W'(1);
            acc          <= acc_sum;
            rate_valid_o <= 1'b0;
            if (acc_sat) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Comparison starts the cycle rate_o takes its new value.
    rate_bar_encoder #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .BAR_WIDTH     (BAR_WIDTH),
        .LOGARITHMIC   (LOGARITHMIC),
        .BAR_STEP      (BAR_STEP)
    ) u_bar (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_i),
        .start   (terminal && !clear_i),
        .rate    (rate_o),
        .bar     (progress_bar_o)
    );

endmodule

// File: tb/tb_cluster_rate_meter.sv
// Directed bench: log, linear and 12-bit saturating meters share one stimulus
// stream; cycle numbers count from reset release (window = 10 cycles).
module tb_cluster_rate_meter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  increment;
    logic        clear;

    logic [31:0] rate_log, rate_lin;
    logic [11:0] rate_sat;
    logic        valid_log, valid_lin, valid_sat;
    logic [7:0]  bar_log, bar_lin, bar_sat;
    logic        ovf_log, ovf_lin, ovf_sat;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;

    cluster_rate_meter #(.CLK_FREQUENCY(160), .SPEEDUP_FACTOR(4), .COUNTER_WIDTH(32),
                         .LOGARITHMIC(1)) dut_log (
        .clock(clock), .reset_n(reset_n), .increment_i(increment), .clear_i(clear),
        .rate_o(rate_log), .rate_valid_o(valid_log), .progress_bar_o(bar_log),
        .overflow_o(ovf_log));

    cluster_rate_meter #(.CLK_FREQUENCY(160), .SPEEDUP_FACTOR(4), .COUNTER_WIDTH(32),
                         .LOGARITHMIC(0), .BAR_STEP(100)) dut_lin (
        .clock(clock), .reset_n(reset_n), .increment_i(increment), .clear_i(clear),
        .rate_o(rate_lin), .rate_valid_o(valid_lin), .progress_bar_o(bar_lin),
        .overflow_o(ovf_lin));

    cluster_rate_meter #(.CLK_FREQUENCY(160), .SPEEDUP_FACTOR(4), .COUNTER_WIDTH(12),
                         .LOGARITHMIC(1)) dut_sat (
        .clock(clock), .reset_n(reset_n), .increment_i(increment), .clear_i(clear),
        .rate_o(rate_sat), .rate_valid_o(valid_sat), .progress_bar_o(bar_sat),
        .overflow_o(ovf_sat));

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        increment = 8'd0;
        clear     = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset rate",     rate_log,  0);
        check("reset valid",    valid_log, 0);
        check("reset bar",      bar_log,   0);
        check("reset overflow", ovf_log,   0);

        // Window 1 (cycles 0..9): increment 1 -> 10 * 16 = 160 Hz
        reset_n   = 1'b1;
        increment = 8'd1;
        cyc       = 0;
        go(9);  check("no valid before T+1", valid_log, 0);
        go(10);
        check("w1 valid log", valid_log, 1);
        check("w1 valid lin", valid_lin, 1);
        check("w1 rate log",  rate_log,  160);
        check("w1 rate sat",  rate_sat,  160);
        increment = 8'd3;
        go(11); check("valid one cycle", valid_log, 0);
        go(17); check("bar holds during CMP", bar_log, 0);
        go(18);
        check("w1 bar log", bar_log, 8'b0000_0011);
        check("w1 bar lin", bar_lin, 8'b0000_0001);
        check("w1 bar sat", bar_sat, 8'b0000_0011);

        // Window 2 (10..19): increment 3 -> 480 Hz
        go(20);
        check("w2 rate lin", rate_lin, 480);
        check("w2 rate log", rate_log, 480);
        increment = 8'd0;
        go(28);
        check("w2 bar lin", bar_lin, 8'b0000_1111);
        check("w2 bar log", bar_log, 8'b0000_0011);
        check("w2 no overflow lin", ovf_lin, 0);

        // Window 3 (20..29): only the terminal cycle carries 5 -> 80 Hz
        go(29); increment = 8'd5;
        go(30); increment = 8'd0;
        check("w3 valid",      valid_log, 1);
        check("w3 rate log",   rate_log,  80);
        check("w3 rate lin",   rate_lin,  80);
        go(38);
        check("w3 bar log",    bar_log, 8'b0000_0001);
        check("w3 bar lin",    bar_lin, 8'b0000_0000);

        // Window 4 (30..39): idle -> 0 Hz
        go(40);
        check("w4 valid",      valid_log, 1);
        check("w4 rate log",   rate_log,  0);
        increment = 8'd255;
        go(48); check("w4 bar log", bar_log, 0);

        // Window 5 (40..49): 255 per cycle -> 40800 Hz, saturates at 12 bits
        go(49); check("sat overflow before T+1", ovf_sat, 0);
        go(50);
        check("w5 rate sat",     rate_sat, 12'hFFF);
        check("w5 overflow sat", ovf_sat,  1);
        check("w5 rate log",     rate_log, 40800);
        check("w5 overflow log", ovf_log,  0);
        increment = 8'd1;
        go(58);
        check("w5 bar sat", bar_sat, 8'b1111_1111);
        check("w5 bar log", bar_log, 8'b0000_1111);
        check("w5 bar lin", bar_lin, 8'b1111_1111);

        // Window 6 (50..59): 160 Hz, overflow stays sticky
        go(60);
        check("w6 rate sat",       rate_sat, 160);
        check("w6 overflow stays", ovf_sat,  1);
        increment = 8'd7;
        go(68); check("w6 bar log", bar_log, 8'b0000_0011);

        // clear_i on the terminal cycle of window 7
        go(69);
        check("pre-clear rate", rate_log, 160);
        clear = 1'b1;
        go(70);
        clear = 1'b0;
        check("clear no valid",     valid_log, 0);
        check("clear rate",         rate_log,  0);
        check("clear bar log",      bar_log,   0);
        check("clear bar lin",      bar_lin,   0);
        check("clear overflow sat", ovf_sat,   0);
        go(78); check("no bar update after clear", bar_log, 0);
        go(79); check("restarted window not closed", valid_log, 0);
        go(80);
        check("post-clear valid",    valid_log, 1);
        check("post-clear rate log", rate_log,  1120);
        check("post-clear rate sat", rate_sat,  1120);
        check("post-clear ovf sat",  ovf_sat,   0);
        increment = 8'd1;

        // Reset in the middle of CMP
        go(83);
        reset_n = 1'b0;
        #1;
        check("mid-CMP reset rate",  rate_log,  0);
        check("mid-CMP reset valid", valid_log, 0);
        check("mid-CMP reset bar",   bar_log,   0);
        check("mid-CMP reset ovf",   ovf_log,   0);
        tick(); tick(); tick();
        check("reset held bar", bar_log, 0);
        reset_n = 1'b1;
        cyc     = 0;
        go(9);  check("post-reset no early valid", valid_log, 0);
        go(10);
        check("post-reset valid", valid_log, 1);
        check("post-reset rate",  rate_log,  160);
        go(17); check("post-reset bar hold", bar_log, 0);
        go(18); check("post-reset bar",      bar_log, 8'b0000_0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
